// File: rtl/sorted_stream_collector_if.sv
// Sample stream from the merge sorter into the collector (SortOut/OutValid).
interface sorted_stream_collector_if #(
  parameter int DATA_W = 8
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data);
  modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/sorted_stream_collector.sv
// Captures one descending-sorted frame into a readable buffer and publishes max/min/median/sum.
// Optional order checking is enabled by defining COLLECTOR_ORDER_CHECK_EN.
module sorted_stream_collector #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  sorted_stream_collector_if.slave                    s,
  output logic                                        frame_done,
  output logic signed [DATA_W-1:0]                    max_out,
  output logic signed [DATA_W-1:0]                    min_out,
  output logic signed [DATA_W-1:0]                    median_out,
  output logic signed [DATA_W+$clog2(FRAME_LEN)-1:0]  sum_out,
  output logic                                        order_err,
  output logic                                        busy,
  input  logic [$clog2(FRAME_LEN)-1:0]                rd_addr,
  output logic signed [DATA_W-1:0]                    rd_data
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int SUM_W = DATA_W + CNT_W;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]               state;
  logic [CNT_W-1:0]         idx;
  logic signed [SUM_W-1:0]  acc;
  logic signed [DATA_W-1:0] mem [FRAME_LEN];

  logic                     first;
  logic                     last;
  logic signed [SUM_W-1:0]  acc_next;
  logic                     err_next;

  always_comb begin
    first    = (idx == '0);
    last     = (idx == CNT_W'(FRAME_LEN - 1));
    // Restarting from zero at idx 0 lets a back-to-back frame begin without a bubble.
    acc_next = (first ? SUM_W'(0) : acc) + SUM_W'(s.in_data);
  end

`ifdef COLLECTOR_ORDER_CHECK_EN
  logic signed [DATA_W-1:0] prev;
  logic                     err_seen;

  always_comb begin
    err_next = 1'b0;
    if (!first)
      err_next = err_seen | (s.in_data > prev);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= '0;
      err_seen <= 1'b0;
    end else if (s.in_valid) begin
      prev     <= s.in_data;
      err_seen <= err_next;
    end
  end
`else
  always_comb err_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      frame_done <= 1'b0;
      max_out    <= '0;
      min_out    <= '0;
      median_out <= '0;
      sum_out    <= '0;
      order_err  <= 1'b0;
    end else begin
      frame_done <= s.in_valid && last;
      if (s.in_valid) begin
        idx   <= idx + 1'b1;
        acc   <= acc_next;
        state <= last ? IDLE : COLLECT;
        if (last) begin
          // Sample 0 and the median slot are already in the buffer; the final sample is live.
          max_out    <= mem[0];
          min_out    <= s.in_data;
          median_out <= mem[FRAME_LEN/2];
          sum_out    <= acc_next;
          order_err  <= err_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FRAME_LEN; i++)
        mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (s.in_valid)
        mem[idx] <= s.in_data;
      rd_data <= mem[rd_addr];
    end
  end

  assign busy = (state == COLLECT);
endmodule

// File: tb/tb_sorted_stream_collector.sv
// Directed and randomized checks of sorted_stream_collector against a frame-level queue model.
module tb_sorted_stream_collector;
  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 32;
  localparam int CNT_W     = 5;

  typedef int q_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sorted_stream_collector_if #(.DATA_W(DATA_W)) bus ();

  logic                          frame_done;
  logic signed [DATA_W-1:0]      max_out, min_out, median_out, rd_data;
  logic signed [DATA_W+CNT_W-1:0] sum_out;
  logic                          order_err, busy;
  logic [CNT_W-1:0]              rd_addr;

  sorted_stream_collector #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst(rst), .s(bus),
    .frame_done(frame_done), .max_out(max_out), .min_out(min_out),
    .median_out(median_out), .sum_out(sum_out), .order_err(order_err),
    .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int q[$];
  int bufm[FRAME_LEN];
  int e_max, e_min, e_med, e_sum, e_err, e_done;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string tag, logic signed [31:0] got, int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("frame_done", {31'b0, frame_done}, e_done);
    chk("busy", {31'b0, busy}, int'(q.size() != 0));
    chk("max_out", max_out, e_max);
    chk("min_out", min_out, e_min);
    chk("median_out", median_out, e_med);
    chk("sum_out", sum_out, e_sum);
    chk("order_err", {31'b0, order_err}, e_err);
  endtask

  task automatic close_frame();
    e_max = q[0];
    e_min = q[FRAME_LEN-1];
    e_med = q[FRAME_LEN/2];
    e_sum = 0;
    foreach (q[i]) e_sum += q[i];
    e_err = 0;
`ifdef COLLECTOR_ORDER_CHECK_EN
    for (int i = 1; i < FRAME_LEN; i++)
      if (q[i] > q[i-1]) e_err = 1;
`endif
    e_done = 1;
    q.delete();
  endtask

  task automatic step(bit v, int d);
    bus.in_valid = v;
    bus.in_data  = DATA_W'(d);
    e_done = 0;
    if (v) begin
      bufm[q.size()] = d;
      q.push_back(d);
      if (q.size() == FRAME_LEN) close_frame();
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    q.delete();
    foreach (bufm[i]) bufm[i] = 0;
    {e_max, e_min, e_med, e_sum, e_err, e_done} = '0;
    @(negedge clk);
    check_all();
    chk("rd_data_reset", rd_data, 0);
    rst = 1'b1;
  endtask

  task automatic rd_chk(int a);
    rd_addr = CNT_W'(a);
    step(1'b0, 0);
    chk("rd_data", rd_data, bufm[a]);
  endtask

  task automatic send_frame(q_t vals, int gap_after, int gap_len);
    foreach (vals[i]) begin
      step(1'b1, vals[i]);
      if (i == gap_after)
        repeat (gap_len) step(1'b0, 0);
    end
  endtask

  function automatic q_t ramp(int hi);
    q_t r;
    for (int i = 0; i < FRAME_LEN; i++) r.push_back(hi - i);
    return r;
  endfunction

  initial begin
    q_t f;
    rd_addr = '0;
    do_reset();

    // 1) basic descending frame
    send_frame(ramp(31), -1, 0);
    step(1'b0, 0);
    // 2) all minimum value
    f = {};
    repeat (FRAME_LEN) f.push_back(-128);
    send_frame(f, -1, 0);
    step(1'b0, 0);
    // 3) five-cycle gap after sample 10
    send_frame(ramp(31), 10, 5);
    step(1'b0, 0);
    // 4) back-to-back frames
    send_frame(ramp(31), -1, 0);
    send_frame(ramp(63), -1, 0);
    step(1'b0, 0);
    // 5) one rising step, then a clean frame
    f = ramp(31);
    f[20] = f[19] + 1;
    send_frame(f, -1, 0);
    send_frame(ramp(31), -1, 0);
    // 6) reset mid-frame, then full frame and readback
    f = ramp(31);
    for (int i = 0; i < 12; i++) step(1'b1, f[i]);
    do_reset();
    send_frame(ramp(31), -1, 0);
    rd_chk(5);
    rd_chk(0);
    rd_chk(FRAME_LEN-1);

    // randomized frames: sorted, occasional inversions, random gaps, back-to-back
    for (int fr = 0; fr < 24; fr++) begin
      f = {};
      repeat (FRAME_LEN) f.push_back(int'($urandom_range(0, 255)) - 128);
      f.rsort();
      if ($urandom_range(0, 2) == 0) begin
        int k = int'($urandom_range(1, FRAME_LEN-1));
        int t = f[k];
        f[k] = f[k-1];
        f[k-1] = t;
      end
      foreach (f[i]) begin
        step(1'b1, f[i]);
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(0, 3)) step(1'b0, 0);
      end
      if ($urandom_range(0, 1) == 0) begin
        rd_chk(int'($urandom_range(0, FRAME_LEN-1)));
        rd_chk(FRAME_LEN/2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
